// File: rtl/gate_test_pkg.sv
// Shared types and sizing helpers for the gate test sequencer.
package gate_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic int nvec(input int n_in);
    return 1 << n_in;
  endfunction

  // One extra bit so an all-vectors-failed sweep still fits.
  function automatic int err_w(input int n_in);
    return n_in + 1;
  endfunction

  function automatic int timer_w(input int settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

endpackage

// File: rtl/gate_test_sequencer_settle_timer.sv
// Loadable down-counter timing how long each stimulus vector is held before sampling.
module settle_timer #(
  parameter int            W        = 1,
  parameter logic [W-1:0]  LOAD_VAL = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gate_test_sequencer.sv
// Sweeps every input vector of a small gate, samples its output after a settle
// interval and accumulates mismatches against an expected truth table.
module gate_test_sequencer
  import gate_test_pkg::*;
#(
  parameter int                   N_IN   = 2,
  parameter logic [(1<<N_IN)-1:0] TRUTH  = 4'b1000,
  parameter int                   SETTLE = 2,
  localparam int                  NVEC   = nvec(N_IN),
  localparam int                  EW     = err_w(N_IN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            gate_out,
  output logic [N_IN-1:0] gate_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [EW-1:0]   err_count,
  output logic [NVEC-1:0] fail_vec,
  output state_t          dbg_state
);

  // start is a level, not a handshake: it is looked at only while IDLE and is
  // otherwise ignored; holding it high re-arms a sweep right after done.

  localparam int              TW       = timer_w(SETTLE);
  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NVEC - 1);

  state_t          state, state_d;
  logic [N_IN-1:0] vec, vec_d;
  logic [EW-1:0]   err_d;
  logic [NVEC-1:0] fail_d;
  logic            pass_d;
  logic            timer_load, timer_dec, timer_zero;
  logic            mismatch;
  logic            busy_d;

  settle_timer #(
    .W        (TW),
    .LOAD_VAL (TW'(SETTLE - 1))
  ) u_settle_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .dec  (timer_dec),
    .zero (timer_zero)
  );

  assign mismatch = (gate_out != TRUTH[vec]);

  always_comb begin
    state_d    = state;
    vec_d      = vec;
    err_d      = err_count;
    fail_d     = fail_vec;
    pass_d     = pass;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SETTLE;
          vec_d      = '0;
          err_d      = '0;
          fail_d     = '0;
          pass_d     = 1'b0;
          timer_load = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (timer_zero) begin
          state_d = ST_SAMPLE;
        end else begin
          timer_dec = 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (mismatch) begin
          err_d       = err_count + EW'(1);
          fail_d[vec] = 1'b1;
        end
        // Explicit last-vector compare; the counter is never allowed to wrap.
        if (vec == LAST_VEC) begin
          state_d = ST_DONE;
          pass_d  = (err_d == '0);
        end else begin
          state_d    = ST_SETTLE;
          vec_d      = vec + N_IN'(1);
          timer_load = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);

  // Outputs are registered from next-state values so they line up with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      vec       <= '0;
      gate_in   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
    end else begin
      state     <= state_d;
      vec       <= vec_d;
      gate_in   <= busy_d ? vec_d : '0;
      busy      <= busy_d;
      done      <= (state_d == ST_DONE);
      pass      <= pass_d;
      err_count <= err_d;
      fail_vec  <= fail_d;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Bench for gate_test_sequencer: three parameterisations checked every cycle
// against a timeline model, plus directed scenarios with literal expectations.
module tb_gate_test_sequencer;
  import gate_test_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] start;
  logic [2:0] stuck;

  logic [1:0] gin_a, gin_x;
  logic [2:0] gin_c;
  logic       busy_a, busy_x, busy_c, done_a, done_x, done_c, pass_a, pass_x, pass_c;
  logic [2:0] err_a, err_x;
  logic [3:0] err_c, fail_a, fail_x;
  logic [7:0] fail_c;
  logic       gout_a, gout_x, gout_c;
  state_t     st_a, st_x, st_c;

  // Gates under test: AND gates, optionally forced stuck-at-0.
  assign gout_a = stuck[0] ? 1'b0 : &gin_a;
  assign gout_x = stuck[1] ? 1'b0 : &gin_x;
  assign gout_c = stuck[2] ? 1'b0 : &gin_c;

  gate_test_sequencer #(.N_IN(2), .TRUTH(4'b1000), .SETTLE(2)) dut_a (
    .clk(clk), .rst(rst), .start(start[0]), .gate_out(gout_a), .gate_in(gin_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .fail_vec(fail_a),
    .dbg_state(st_a));

  gate_test_sequencer #(.N_IN(2), .TRUTH(4'b0110), .SETTLE(2)) dut_x (
    .clk(clk), .rst(rst), .start(start[1]), .gate_out(gout_x), .gate_in(gin_x),
    .busy(busy_x), .done(done_x), .pass(pass_x), .err_count(err_x), .fail_vec(fail_x),
    .dbg_state(st_x));

  gate_test_sequencer #(.N_IN(3), .TRUTH(8'h80), .SETTLE(1)) dut_c (
    .clk(clk), .rst(rst), .start(start[2]), .gate_out(gout_c), .gate_in(gin_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c), .fail_vec(fail_c),
    .dbg_state(st_c));

  logic [7:0] a_gin[3], a_err[3], a_fail[3];
  logic       a_busy[3], a_done[3], a_pass[3];
  assign a_gin[0]  = 8'(gin_a);  assign a_gin[1]  = 8'(gin_x);  assign a_gin[2]  = 8'(gin_c);
  assign a_err[0]  = 8'(err_a);  assign a_err[1]  = 8'(err_x);  assign a_err[2]  = 8'(err_c);
  assign a_fail[0] = 8'(fail_a); assign a_fail[1] = 8'(fail_x); assign a_fail[2] = fail_c;
  assign a_busy[0] = busy_a; assign a_busy[1] = busy_x; assign a_busy[2] = busy_c;
  assign a_done[0] = done_a; assign a_done[1] = done_x; assign a_done[2] = done_c;
  assign a_pass[0] = pass_a; assign a_pass[1] = pass_x; assign a_pass[2] = pass_c;

  int n_in[3]  = '{2, 2, 3};
  int sett[3]  = '{2, 2, 1};
  int truth[3] = '{8, 6, 128};

  int vectors_applied = 0;
  int miscompares     = 0;
  bit checking        = 1'b0;

  task automatic check(input string name, input int idx, input int act, input int exp);
    vectors_applied++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s[dut%0d]: got %0d, expected %0d at %0t", name, idx, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int sweep_len(input int i);
    return (1 << n_in[i]) * (sett[i] + 1);
  endfunction

  function automatic bit mism(input int i, input int k);
    bit g;
    g = stuck[i] ? 1'b0 : (k == (1 << n_in[i]) - 1);
    return g != bit'((truth[i] >> k) & 1);
  endfunction

  // Vector k has been sampled once (k+1)*(SETTLE+1) cycles of the sweep elapsed.
  task automatic model_errs(input int i, input int tt, output int e, output int f);
    e = 0;
    f = 0;
    for (int k = 0; k < (1 << n_in[i]); k++) begin
      if ((k + 1) * (sett[i] + 1) <= tt && mism(i, k)) begin
        e++;
        f |= (1 << k);
      end
    end
  endtask

  bit active[3];
  int t[3];
  int h_err[3], h_fail[3];
  bit h_pass[3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int e, f;
      if (rst) begin
        active[i] = 1'b0; t[i] = 0; h_err[i] = 0; h_fail[i] = 0; h_pass[i] = 1'b0;
      end else if (active[i]) begin
        if (t[i] == sweep_len(i)) begin
          model_errs(i, t[i], e, f);
          h_err[i] = e; h_fail[i] = f; h_pass[i] = (e == 0);
          active[i] = 1'b0;
        end else begin
          t[i]++;
        end
      end else if (start[i]) begin
        active[i] = 1'b1;
        t[i] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < 3; i++) begin
        int e, f, gin_e;
        bit busy_e, done_e, pass_e;
        busy_e = active[i] && (t[i] < sweep_len(i));
        done_e = active[i] && (t[i] == sweep_len(i));
        gin_e  = busy_e ? t[i] / (sett[i] + 1) : 0;
        if (active[i]) begin
          model_errs(i, t[i], e, f);
          pass_e = done_e ? (e == 0) : 1'b0;
        end else begin
          e = h_err[i]; f = h_fail[i]; pass_e = h_pass[i];
        end
        check("busy", i, int'(a_busy[i]), int'(busy_e));
        check("done", i, int'(a_done[i]), int'(done_e));
        check("gate_in", i, int'(a_gin[i]), gin_e);
        check("err_count", i, int'(a_err[i]), e);
        check("fail_vec", i, int'(a_fail[i]), f);
        check("pass", i, int'(a_pass[i]), int'(pass_e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic sweep(input int i, input bit repulse, output int busy_cyc, output int done_cnt);
    start[i] = 1'b1;
    step();
    start[i] = 1'b0;
    busy_cyc = 0;
    done_cnt = 0;
    for (int c = 0; c < sweep_len(i) + 6; c++) begin
      if (a_busy[i]) busy_cyc++;
      if (a_done[i]) done_cnt++;
      start[i] = repulse && (c == 4 || a_done[i]);
      step();
    end
    start[i] = 1'b0;
  endtask

  initial begin
    int bc, dc, dones;
    int hold[3];
    rst = 1'b1; start = '0; stuck = '0;
    repeat (3) step();
    checking = 1'b1;
    check("rst_state", 0, int'(st_a), int'(ST_IDLE));
    check("rst_err", 2, int'(err_c), 0);
    check("rst_fail", 2, int'(fail_c), 0);
    rst = 1'b0;
    step();

    // 1: good AND gate
    sweep(0, 1'b0, bc, dc);
    check("t1_busy_len", 0, bc, 12);
    check("t1_done_cnt", 0, dc, 1);
    check("t1_pass", 0, int'(pass_a), 1);
    check("t1_err", 0, int'(err_a), 0);
    check("t1_fail", 0, int'(fail_a), 0);

    // 2: stuck-at-0
    stuck[0] = 1'b1;
    sweep(0, 1'b0, bc, dc);
    check("t2_pass", 0, int'(pass_a), 0);
    check("t2_err", 0, int'(err_a), 1);
    check("t2_fail", 0, int'(fail_a), 4'b1000);
    stuck[0] = 1'b0;

    // 3: AND gate against XOR table
    sweep(1, 1'b0, bc, dc);
    check("t3_err", 1, int'(err_x), 3);
    check("t3_fail", 1, int'(fail_x), 4'b1110);
    check("t3_pass", 1, int'(pass_x), 0);

    // 4: re-pulsed start mid-sweep and during done
    sweep(0, 1'b1, bc, dc);
    check("t4_busy_len", 0, bc, 12);
    check("t4_done_cnt", 0, dc, 1);
    check("t4_pass", 0, int'(pass_a), 1);

    // 5: reset in the fifth busy cycle
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    repeat (4) step();
    check("t5_busy_before_rst", 0, int'(busy_a), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_busy_after_rst", 0, int'(busy_a), 0);
    check("t5_gate_in_after_rst", 0, int'(gin_a), 0);
    check("t5_state_after_rst", 0, int'(st_a), int'(ST_IDLE));
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      if (done_a) dones++;
      step();
    end
    check("t5_no_done", 0, dones, 0);
    sweep(0, 1'b0, bc, dc);
    check("t5_fresh_busy_len", 0, bc, 12);
    check("t5_fresh_pass", 0, int'(pass_a), 1);

    // 6: 3-input AND, SETTLE=1
    sweep(2, 1'b0, bc, dc);
    check("t6_busy_len", 2, bc, 16);
    check("t6_done_cnt", 2, dc, 1);
    check("t6_pass", 2, int'(pass_c), 1);

    // Randomised: pulses, held starts, occasional resets with new fault settings
    hold = '{0, 0, 0};
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (hold[i] > 0) begin
          start[i] = 1'b1;
          hold[i]--;
        end else begin
          start[i] = 1'b0;
          if ($urandom_range(0, 9) == 0) hold[i] = $urandom_range(1, 40);
        end
      end
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        stuck = 3'($urandom_range(0, 7));
      end else begin
        step();
      end
    end
    start = '0;
    repeat (30) step();

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
